// File: rtl/register_file_pkg.sv
// Shared types, sizes and the operand read mux for the register file.
// The read mux is a function so both source ports get identical bypass logic.
package register_file_pkg;

   localparam int ROB_SIZE = 16;
   localparam int ROB_ID_W = 5;
   localparam int REG_NUM  = 32;

   typedef logic [31:0]         data_t;
   typedef logic [4:0]          reg_pos_t;
   typedef logic [ROB_ID_W-1:0] rob_id_t;

   localparam data_t    ZERO_WORD = '0;
   localparam reg_pos_t ZERO_REG  = '0;
   localparam rob_id_t  ZERO_ROB  = '0;

   typedef struct packed {
      data_t   v;
      rob_id_t q;
   } rd_port_t;

   // A commit whose tag still owns the register is forwarded in the same cycle.
   function automatic rd_port_t rf_read(
      input reg_pos_t src,
      input data_t    cur_v,
      input rob_id_t  cur_q,
      input logic     commit,
      input reg_pos_t commit_rd,
      input rob_id_t  commit_q,
      input data_t    commit_v
   );
      rd_port_t r;
      r.v = cur_v;
      r.q = cur_q;
      if (src == ZERO_REG) begin
         r.v = ZERO_WORD;
         r.q = ZERO_ROB;
      end else if (commit && commit_rd == src
                   && cur_q == commit_q) begin
         r.v = commit_v;
         r.q = ZERO_ROB;
      end
      return r;
   endfunction

endpackage

// File: rtl/register_file_if.sv
// Dispatcher and ROB side signals of the register file.
// master drives requests (dispatcher/ROB), slave is the register file.
interface register_file_if;
   import register_file_pkg::*;

   reg_pos_t rs1_from_dsp;
   reg_pos_t rs2_from_dsp;
   data_t    V1_to_dsp;
   rob_id_t  Q1_to_dsp;
   data_t    V2_to_dsp;
   rob_id_t  Q2_to_dsp;

   logic     ena_from_dsp;
   reg_pos_t rd_from_dsp;
   rob_id_t  Q_from_dsp;

   logic     commit_flag_from_rob;
   reg_pos_t rd_from_rob;
   rob_id_t  Q_from_rob;
   data_t    V_from_rob;
   logic     rollback_flag_from_rob;

   modport master (
      output rs1_from_dsp, rs2_from_dsp,
      output ena_from_dsp, rd_from_dsp, Q_from_dsp,
      output commit_flag_from_rob, rd_from_rob,
      output Q_from_rob, V_from_rob,
      output rollback_flag_from_rob,
      input  V1_to_dsp, Q1_to_dsp,
      input  V2_to_dsp, Q2_to_dsp
   );

   modport slave (
      input  rs1_from_dsp, rs2_from_dsp,
      input  ena_from_dsp, rd_from_dsp, Q_from_dsp,
      input  commit_flag_from_rob, rd_from_rob,
      input  Q_from_rob, V_from_rob,
      input  rollback_flag_from_rob,
      output V1_to_dsp, Q1_to_dsp,
      output V2_to_dsp, Q2_to_dsp
   );

endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags (Q=0: valid).
// Commits write values, renames write tags, rollback drops every tag.
module register_file
   import register_file_pkg::*;
(
   input logic            clk,
   input logic            rst,
   input logic            rdy,
   register_file_if.slave bus
);

   data_t    value [REG_NUM];
   rob_id_t  tag   [REG_NUM];
   rd_port_t rd1;
   rd_port_t rd2;

   logic commit_wr;
   logic rename_wr;

   assign commit_wr = bus.commit_flag_from_rob
                      && bus.rd_from_rob != ZERO_REG;
   assign rename_wr = bus.ena_from_dsp
                      && !bus.rollback_flag_from_rob
                      && bus.rd_from_dsp != ZERO_REG;

   always_comb begin
      rd1 = rf_read(bus.rs1_from_dsp,
                    value[bus.rs1_from_dsp],
                    tag[bus.rs1_from_dsp],
                    bus.commit_flag_from_rob,
                    bus.rd_from_rob,
                    bus.Q_from_rob,
                    bus.V_from_rob);
      rd2 = rf_read(bus.rs2_from_dsp,
                    value[bus.rs2_from_dsp],
                    tag[bus.rs2_from_dsp],
                    bus.commit_flag_from_rob,
                    bus.rd_from_rob,
                    bus.Q_from_rob,
                    bus.V_from_rob);
   end

   assign bus.V1_to_dsp = rd1.v;
   assign bus.Q1_to_dsp = rd1.q;
   assign bus.V2_to_dsp = rd2.v;
   assign bus.Q2_to_dsp = rd2.q;

   // Later assignments win: rename overrides the commit tag clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            value[i] <= ZERO_WORD;
            tag[i]   <= ZERO_ROB;
         end
      end else if (rdy) begin
         if (bus.rollback_flag_from_rob) begin
            for (int i = 0; i < REG_NUM; i++)
               tag[i] <= ZERO_ROB;
         end
         if (commit_wr) begin
            value[bus.rd_from_rob] <= bus.V_from_rob;
            if (!bus.rollback_flag_from_rob
                && tag[bus.rd_from_rob] == bus.Q_from_rob)
               tag[bus.rd_from_rob] <= ZERO_ROB;
         end
         if (rename_wr)
            tag[bus.rd_from_dsp] <= bus.Q_from_dsp;
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: directed scenarios plus random traffic against
// an array model of values and tags.
module tb_register_file;

   logic clk = 1'b0;
   logic rst;
   logic rdy;

   register_file_if bus ();

   register_file dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] m_val [32];
   logic [4:0]  m_q   [32];

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h @%0t",
                    name, got, exp, $time);
   endtask

   function automatic logic [36:0] m_read(input logic [4:0] s);
      if (s == 0) return '0;
      if (bus.commit_flag_from_rob && bus.rd_from_rob == s
          && m_q[s] == bus.Q_from_rob)
         return {bus.V_from_rob, 5'd0};
      return {m_val[s], m_q[s]};
   endfunction

   task automatic m_update();
      logic [4:0] old_q [32];
      old_q = m_q;
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_val[i] = 0;
            m_q[i]   = 0;
         end
      end else if (rdy) begin
         if (bus.rollback_flag_from_rob)
            for (int i = 0; i < 32; i++) m_q[i] = 0;
         if (bus.commit_flag_from_rob && bus.rd_from_rob != 0) begin
            m_val[bus.rd_from_rob] = bus.V_from_rob;
            if (!bus.rollback_flag_from_rob
                && old_q[bus.rd_from_rob] == bus.Q_from_rob)
               m_q[bus.rd_from_rob] = 0;
         end
         if (bus.ena_from_dsp && !bus.rollback_flag_from_rob
             && bus.rd_from_dsp != 0)
            m_q[bus.rd_from_dsp] = bus.Q_from_dsp;
      end
   endtask

   // Called just after a negedge with inputs set: compare, then clock.
   task automatic tick();
      logic [36:0] e1, e2;
      #1;
      e1 = m_read(bus.rs1_from_dsp);
      e2 = m_read(bus.rs2_from_dsp);
      chk("V1", bus.V1_to_dsp, e1[36:5]);
      chk("Q1", {27'd0, bus.Q1_to_dsp}, {27'd0, e1[4:0]});
      chk("V2", bus.V2_to_dsp, e2[36:5]);
      chk("Q2", {27'd0, bus.Q2_to_dsp}, {27'd0, e2[4:0]});
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 0;
      rdy = 1;
      bus.ena_from_dsp = 0;
      bus.rd_from_dsp = 0;
      bus.Q_from_dsp = 0;
      bus.commit_flag_from_rob = 0;
      bus.rd_from_rob = 0;
      bus.Q_from_rob = 0;
      bus.V_from_rob = 0;
      bus.rollback_flag_from_rob = 0;
   endtask

   task automatic rename(input logic [4:0] rd, input logic [4:0] q);
      bus.ena_from_dsp = 1;
      bus.rd_from_dsp = rd;
      bus.Q_from_dsp = q;
   endtask

   task automatic commit(input logic [4:0] rd, input logic [4:0] q,
                         input logic [31:0] v);
      bus.commit_flag_from_rob = 1;
      bus.rd_from_rob = rd;
      bus.Q_from_rob = q;
      bus.V_from_rob = v;
   endtask

   task automatic lit(input string name, input logic [31:0] v1,
                      input logic [4:0] q1, input logic [31:0] v2,
                      input logic [4:0] q2);
      #1;
      chk({name, ".V1"}, bus.V1_to_dsp, v1);
      chk({name, ".Q1"}, {27'd0, bus.Q1_to_dsp}, {27'd0, q1});
      chk({name, ".V2"}, bus.V2_to_dsp, v2);
      chk({name, ".Q2"}, {27'd0, bus.Q2_to_dsp}, {27'd0, q2});
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_val[i] = 0;
         m_q[i] = 0;
      end
      idle();
      bus.rs1_from_dsp = 0;
      bus.rs2_from_dsp = 0;
      rst = 1;
      @(negedge clk);
      tick();

      // reset state
      idle();
      bus.rs1_from_dsp = 5; bus.rs2_from_dsp = 0;
      lit("reset", 0, 0, 0, 0);
      tick();

      // rename then commit with bypass
      rename(5, 3);
      lit("ren_no_fwd", 0, 0, 0, 0);
      tick();
      idle();
      lit("ren5", 0, 3, 0, 0);
      tick();
      commit(5, 3, 32'hDEADBEEF);
      lit("byp5", 32'hDEADBEEF, 0, 0, 0);
      tick();
      idle();
      lit("post5", 32'hDEADBEEF, 0, 0, 0);
      tick();

      // younger rename keeps its tag
      bus.rs1_from_dsp = 7;
      rename(7, 2); tick();
      rename(7, 4); tick();
      idle();
      commit(7, 2, 32'h11);
      lit("old7", 0, 4, 0, 0);
      tick();
      idle();
      lit("mid7", 32'h11, 4, 0, 0);
      tick();
      commit(7, 4, 32'h22);
      lit("byp7", 32'h22, 0, 0, 0);
      tick();
      idle();
      lit("post7", 32'h22, 0, 0, 0);
      tick();

      // same-cycle commit and rename of one register
      bus.rs1_from_dsp = 9;
      commit(9, 1, 32'h55);
      rename(9, 6);
      tick();
      idle();
      lit("cr9", 32'h55, 6, 0, 0);
      tick();

      // rollback with commit and ignored rename
      rename(3, 2); tick();
      rename(4, 5); tick();
      idle();
      commit(1, 1, 32'h80);
      rename(6, 7);
      bus.rollback_flag_from_rob = 1;
      tick();
      idle();
      bus.rs1_from_dsp = 3; bus.rs2_from_dsp = 4;
      lit("rb34", 0, 0, 0, 0);
      tick();
      bus.rs1_from_dsp = 1; bus.rs2_from_dsp = 6;
      lit("rb16", 32'h80, 0, 0, 0);
      tick();
      bus.rs1_from_dsp = 9; bus.rs2_from_dsp = 7;
      lit("rb97", 32'h55, 0, 32'h22, 0);
      tick();

      // x0 is hardwired
      bus.rs1_from_dsp = 0; bus.rs2_from_dsp = 0;
      commit(0, 0, 32'hFF);
      rename(0, 3);
      lit("x0_byp", 0, 0, 0, 0);
      tick();
      idle();
      lit("x0", 0, 0, 0, 0);
      tick();

      // rdy low holds state
      bus.rs1_from_dsp = 1; bus.rs2_from_dsp = 5;
      rdy = 0;
      commit(2, 0, 32'h1234);
      rename(5, 9);
      bus.rollback_flag_from_rob = 1;
      tick();
      idle();
      bus.rs1_from_dsp = 2; bus.rs2_from_dsp = 5;
      lit("hold", 0, 0, 32'hDEADBEEF, 0);
      tick();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] crd;
         idle();
         rst = ($urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 9) != 0);
         bus.rs1_from_dsp = 5'($urandom_range(0, 7));
         bus.rs2_from_dsp = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1)
            rename(5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 16)));
         if ($urandom_range(0, 1) == 1) begin
            crd = 5'($urandom_range(0, 7));
            commit(crd,
                   ($urandom_range(0, 3) != 0) ? m_q[crd]
                      : 5'($urandom_range(0, 16)),
                   $urandom);
         end
         bus.rollback_flag_from_rob = ($urandom_range(0, 39) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
